// File: rtl/math_divider_radix.sv
// Iterative restoring divider, signed/unsigned, BITS_PER_CYCLE quotient bits per CALC cycle.
// Optional leading-zero skip compiled in with `define MATH_DIVIDER_SKIP_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// PREP  | form magnitudes, detect divide-by-zero
// CALC  | BITS_PER_CYCLE restoring steps per cycle
// FIX   | apply signs, overflow result
// DONE  | result valid, held until consumed
module math_divider_radix #(
  parameter int DATA_WIDTH     = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_b,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder,
  output logic                  o_dbz,
  output logic                  o_ovf,
  output logic                  o_busy
);

  localparam int N  = DATA_WIDTH;
  localparam int K  = BITS_PER_CYCLE;
  localparam int S  = N / K;
  localparam int CW = $clog2(S + 1);
  localparam logic [N-1:0] ONE_N = N'(1);
  localparam logic [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  if (!(K == 1 || K == 2 || K == 4) || (N % K) != 0 || N < 4) begin : g_param_check
    $error("math_divider_radix: illegal DATA_WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_PREP, ST_CALC, ST_FIX, ST_DONE} state_t;

  state_t state, state_nxt;

  logic [N-1:0]  dvd_r, dvs_r, dvs_mag;
  logic          sgn_r;
  logic [N:0]    acc, acc_nxt;
  logic [N-1:0]  quo, quo_nxt;
  logic [CW-1:0] cnt, cnt_init;
  logic          neg_a, neg_b;
  logic [N-1:0]  mag_a, mag_b, quo_init;
  logic [N-1:0]  fix_q, fix_r;
  logic          fix_ovf;
  logic [N-1:0]  q_r, r_r;
  logic          dbz_r, ovf_r;

  always_comb begin
    neg_a = sgn_r & dvd_r[N-1];
    neg_b = sgn_r & dvs_r[N-1];
    mag_a = neg_a ? (~dvd_r + ONE_N) : dvd_r;
    mag_b = neg_b ? (~dvs_r + ONE_N) : dvs_r;
  end

`ifdef MATH_DIVIDER_SKIP_EN
  int lz, g;
  // Skip whole groups of leading zeros; at least one CALC cycle always remains.
  always_comb begin
    lz = N;
    for (int i = 0; i < N; i++) begin
      if (mag_a[i]) lz = N - 1 - i;
    end
    g = lz / K;
    if (g > S - 1) g = S - 1;
    quo_init = mag_a << (g * K);
    cnt_init = CW'(S - g);
  end
`else
  always_comb begin
    quo_init = mag_a;
    cnt_init = CW'(S);
  end
`endif

  always_comb begin
    acc_nxt = acc;
    quo_nxt = quo;
    for (int i = 0; i < K; i++) begin
      acc_nxt = {acc_nxt[N-1:0], quo_nxt[N-1]};
      quo_nxt = {quo_nxt[N-2:0], 1'b0};
      if (acc_nxt >= {1'b0, dvs_mag}) begin
        acc_nxt    = acc_nxt - {1'b0, dvs_mag};
        quo_nxt[0] = 1'b1;
      end
    end
  end

  always_comb begin
    fix_ovf = sgn_r & (dvd_r == MIN_N) & (dvs_r == '1);
    fix_q   = (neg_a ^ neg_b) ? (~quo + ONE_N) : quo;
    fix_r   = neg_a ? (~acc[N-1:0] + ONE_N) : acc[N-1:0];
    if (fix_ovf) begin
      fix_q = MIN_N;
      fix_r = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_valid) state_nxt = ST_PREP;
      ST_PREP: state_nxt = (dvs_r == '0) ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt == CW'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: if (i_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      dvd_r   <= '0;
      dvs_r   <= '0;
      sgn_r   <= 1'b0;
      dvs_mag <= '0;
      acc     <= '0;
      quo     <= '0;
      cnt     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      dbz_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (i_valid) begin
          dvd_r <= i_dividend;
          dvs_r <= i_divisor;
          sgn_r <= i_signed;
        end
        ST_PREP: if (dvs_r == '0) begin
          q_r   <= '1;
          r_r   <= dvd_r;
          dbz_r <= 1'b1;
          ovf_r <= 1'b0;
        end else begin
          acc     <= '0;
          quo     <= quo_init;
          dvs_mag <= mag_b;
          cnt     <= cnt_init;
        end
        ST_CALC: begin
          acc <= acc_nxt;
          quo <= quo_nxt;
          cnt <= cnt - CW'(1);
        end
        ST_FIX: begin
          q_r   <= fix_q;
          r_r   <= fix_r;
          dbz_r <= 1'b0;
          ovf_r <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

  assign o_ready     = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);
  assign o_valid     = (state == ST_DONE);
  assign o_quotient  = q_r;
  assign o_remainder = r_r;
  assign o_dbz       = dbz_r;
  assign o_ovf       = ovf_r;

endmodule

// File: tb/tb_math_divider_radix.sv
// Directed bench for math_divider_radix: one K=1 and one K=2 instance on a shared bus.
module tb_math_divider_radix;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] dvd = '0, dvs = '0;
  logic        rdy = 1'b0;

  logic        ready1, valid1_o, dbz1, ovf1, busy1;
  logic        ready2, valid2_o, dbz2, ovf2, busy2;
  logic [15:0] q1, r1, q2, r2;

  logic        o_ready, o_valid, o_dbz, o_ovf, o_busy;
  logic [15:0] o_q, o_r;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  math_divider_radix #(.DATA_WIDTH(16), .BITS_PER_CYCLE(1)) dut1 (
    .i_clk(clk), .i_rst_b(rst_b), .i_valid(valid & ~sel), .o_ready(ready1),
    .i_signed(sgn), .i_dividend(dvd), .i_divisor(dvs), .o_valid(valid1_o),
    .i_ready(rdy & ~sel), .o_quotient(q1), .o_remainder(r1), .o_dbz(dbz1),
    .o_ovf(ovf1), .o_busy(busy1));

  math_divider_radix #(.DATA_WIDTH(16), .BITS_PER_CYCLE(2)) dut2 (
    .i_clk(clk), .i_rst_b(rst_b), .i_valid(valid & sel), .o_ready(ready2),
    .i_signed(sgn), .i_dividend(dvd), .i_divisor(dvs), .o_valid(valid2_o),
    .i_ready(rdy & sel), .o_quotient(q2), .o_remainder(r2), .o_dbz(dbz2),
    .o_ovf(ovf2), .o_busy(busy2));

  assign o_ready = sel ? ready2   : ready1;
  assign o_valid = sel ? valid2_o : valid1_o;
  assign o_dbz   = sel ? dbz2     : dbz1;
  assign o_ovf   = sel ? ovf2     : ovf1;
  assign o_busy  = sel ? busy2    : busy1;
  assign o_q     = sel ? q2       : q1;
  assign o_r     = sel ? r2       : r1;

  // Accept-to-valid latency for a nonzero divisor, from the dividend magnitude.
  function automatic int exp_lat(input int k, input logic [15:0] mag);
    int s, lz, g;
    s = 16 / k;
    lz = 16;
    g = 0;
`ifdef MATH_DIVIDER_SKIP_EN
    for (int i = 0; i < 16; i++) if (mag[i]) lz = 15 - i;
    g = lz / k;
    if (g > s - 1) g = s - 1;
`endif
    return s - g + 2;
  endfunction

  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    sgn = s; dvd = a; dvs = b; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0; dvd = 16'hDEAD; dvs = 16'hBEEF;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if ({o_busy, o_dbz, o_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {o_busy, o_dbz, o_ovf}); end
    checks++; if ({o_q, o_r} !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", {o_q, o_r}); end
    @(negedge clk) rst_b = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    sel = 1'b0;
    run_op(1'b0, 16'd100, 16'd7, lat);
    checks++; if (lat !== exp_lat(1, 16'd100)) begin errors++; $display("FAIL u100_7_latency: got %0d want %0d", lat, exp_lat(1, 16'd100)); end
    checks++; if ({o_q, o_r} !== {16'd14, 16'd2}) begin errors++; $display("FAIL u100_7_qr: got %h want %h", {o_q, o_r}, {16'd14, 16'd2}); end
    checks++; if ({o_dbz, o_ovf} !== 2'b00) begin errors++; $display("FAIL u100_7_flags: got %b want 00", {o_dbz, o_ovf}); end
    release_op();
    checks++; if ({o_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL u100_7_release: got %b want 01", {o_valid, o_ready}); end
  endtask

  task automatic test_signed();
    int lat;
    sel = 1'b0;
    run_op(1'b1, 16'hFF9C, 16'h0007, lat);
    checks++; if (lat !== exp_lat(1, 16'd100)) begin errors++; $display("FAIL sneg_latency: got %0d want %0d", lat, exp_lat(1, 16'd100)); end
    checks++; if ({o_q, o_r} !== 32'hFFF2_FFFE) begin errors++; $display("FAIL sneg_qr: got %h want FFF2FFFE", {o_q, o_r}); end
    release_op();
    run_op(1'b1, 16'h0064, 16'hFFF9, lat);
    checks++; if ({o_q, o_r} !== 32'hFFF2_0002) begin errors++; $display("FAIL sdiv_neg_qr: got %h want FFF20002", {o_q, o_r}); end
    checks++; if ({o_dbz, o_ovf} !== 2'b00) begin errors++; $display("FAIL sdiv_neg_flags: got %b want 00", {o_dbz, o_ovf}); end
    release_op();
  endtask

  task automatic test_dbz_ovf();
    int lat;
    sel = 1'b0;
    run_op(1'b0, 16'h1234, 16'h0000, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    checks++; if ({o_q, o_r} !== 32'hFFFF_1234) begin errors++; $display("FAIL dbz_qr: got %h want FFFF1234", {o_q, o_r}); end
    checks++; if ({o_dbz, o_ovf} !== 2'b10) begin errors++; $display("FAIL dbz_flags: got %b want 10", {o_dbz, o_ovf}); end
    release_op();
    run_op(1'b1, 16'h8000, 16'hFFFF, lat);
    checks++; if (lat !== exp_lat(1, 16'h8000)) begin errors++; $display("FAIL ovf_latency: got %0d want %0d", lat, exp_lat(1, 16'h8000)); end
    checks++; if ({o_q, o_r} !== 32'h8000_0000) begin errors++; $display("FAIL ovf_qr: got %h want 80000000", {o_q, o_r}); end
    checks++; if ({o_dbz, o_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags: got %b want 01", {o_dbz, o_ovf}); end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 1'b0;
    run_op(1'b0, 16'd1000, 16'd10, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid = 1'b1; dvd = 16'd5; dvs = 16'd1;
      checks++; if ({o_valid, o_ready, o_busy, o_q, o_r} !== {3'b101, 16'd100, 16'd0}) begin
        errors++; $display("FAIL hold_cycle%0d: got %h want %h", c, {o_valid, o_ready, o_busy, o_q, o_r}, {3'b101, 16'd100, 16'd0});
      end
    end
    @(negedge clk) valid = 1'b0;
    release_op();
    checks++; if ({o_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL hold_release: got %b want 01", {o_valid, o_ready}); end
    @(posedge clk) #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL hold_no_queue: busy got %b want 0", o_busy); end
  endtask

  task automatic test_radix4();
    int lat;
    logic seen;
    sel = 1'b1;
    run_op(1'b0, 16'hFFFF, 16'h0003, lat);
    checks++; if (lat !== exp_lat(2, 16'hFFFF)) begin errors++; $display("FAIL k2_latency: got %0d want %0d", lat, exp_lat(2, 16'hFFFF)); end
    checks++; if ({o_q, o_r} !== 32'h5555_0000) begin errors++; $display("FAIL k2_qr: got %h want 55550000", {o_q, o_r}); end
    release_op();
    @(negedge clk);
    sgn = 1'b0; dvd = 16'hFFFF; dvs = 16'h0003; valid = 1'b1;
    @(posedge clk) #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({o_busy, o_valid} !== 2'b10) begin errors++; $display("FAIL k2_midcalc: got %b want 10", {o_busy, o_valid}); end
    @(negedge clk) rst_b = 1'b0;
    #1;
    checks++; if ({o_ready, o_valid, o_busy} !== 3'b100) begin errors++; $display("FAIL abort_state: got %b want 100", {o_ready, o_valid, o_busy}); end
    checks++; if (o_q !== 16'h0) begin errors++; $display("FAIL abort_data: got %h want 0000", o_q); end
    @(negedge clk) rst_b = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk) #1;
      if (o_valid || !o_ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet: got %b want 0", seen); end
  endtask

  task automatic test_skip();
    int lat;
    sel = 1'b0;
    run_op(1'b0, 16'd5, 16'd2, lat);
    checks++; if (lat !== exp_lat(1, 16'd5)) begin errors++; $display("FAIL u5_2_latency: got %0d want %0d", lat, exp_lat(1, 16'd5)); end
    checks++; if ({o_q, o_r} !== {16'd2, 16'd1}) begin errors++; $display("FAIL u5_2_qr: got %h want %h", {o_q, o_r}, {16'd2, 16'd1}); end
    release_op();
    run_op(1'b0, 16'd0, 16'd9, lat);
    checks++; if (lat !== exp_lat(1, 16'd0)) begin errors++; $display("FAIL u0_9_latency: got %0d want %0d", lat, exp_lat(1, 16'd0)); end
    checks++; if ({o_q, o_r, o_dbz} !== 33'h0) begin errors++; $display("FAIL u0_9_qr: got %h want 0", {o_q, o_r, o_dbz}); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz_ovf();
    test_backpressure();
    test_radix4();
    test_skip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
